// File: rtl/lib_switch_allocator.sv
// Per-output round-robin switch allocator: one-hot requests in,
// one-hot crossbar selects and FIFO pop strobes out.
module lib_switch_allocator #(
   parameter int RADIX = 5
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [0:RADIX-1][0:RADIX-1]  i_req,
   input  logic [0:RADIX-1]             i_en,
   output logic [0:RADIX-1][0:RADIX-1]  o_output_grant,
   output logic [0:RADIX-1]             o_input_grant,
   output logic                         o_err
);

   localparam int PW = (RADIX > 1) ? $clog2(RADIX) : 1;

   logic [PW-1:0]               r_ptr [RADIX];
   logic                        r_err;
   logic [0:RADIX-1]            w_multi;
   logic [0:RADIX-1]            w_hit;
   logic [PW-1:0]               w_win [RADIX];
   logic [0:RADIX-1][0:RADIX-1] w_grant;
   logic [0:RADIX-1]            w_igrant;

   function automatic logic [PW-1:0] f_wrap(input logic [PW-1:0] p,
                                            input int k);
      int s;
      s = int'(p) + k;
      if (s >= RADIX) s = s - RADIX;
      return PW'(s);
   endfunction

   // Multi-hot requesters are dropped from arbitration entirely.
   always_comb begin
      w_multi = '0;
      for (int i = 0; i < RADIX; i++)
         w_multi[i] = ($countones(i_req[i]) > 1);
   end

   always_comb begin
      w_grant = '0;
      w_hit   = '0;
      for (int o = 0; o < RADIX; o++) begin
         w_win[o] = '0;
         for (int k = 0; k < RADIX; k++) begin
            if (!w_hit[o] && reset_n && i_en[o] &&
                !w_multi[f_wrap(r_ptr[o], k)] &&
                i_req[f_wrap(r_ptr[o], k)][o]) begin
               w_hit[o]   = 1'b1;
               w_win[o]   = f_wrap(r_ptr[o], k);
               w_grant[o][f_wrap(r_ptr[o], k)] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_igrant = '0;
      for (int o = 0; o < RADIX; o++)
         for (int i = 0; i < RADIX; i++)
            w_igrant[i] = w_igrant[i] | w_grant[o][i];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int o = 0; o < RADIX; o++)
            r_ptr[o] <= '0;
         r_err <= 1'b0;
      end else begin
         for (int o = 0; o < RADIX; o++)
            if (w_hit[o]) r_ptr[o] <= f_wrap(w_win[o], 1);
         if (|w_multi) r_err <= 1'b1;
      end
   end

   assign o_output_grant = w_grant;
   assign o_input_grant  = w_igrant;
   assign o_err          = r_err;

endmodule

// File: tb/tb_lib_switch_allocator.sv
// Directed bench for lib_switch_allocator (RADIX = 5) with an
// expectation queue popped against the combinational grant outputs.
module tb_lib_switch_allocator;

   typedef logic [0:4]      vec_t;
   typedef logic [0:4][0:4] mat_t;

   typedef struct {
      string tag;
      mat_t  og;
      vec_t  ig;
      logic  err;
   } exp_t;

   logic clk;
   logic reset_n;
   mat_t i_req;
   vec_t i_en;
   mat_t o_output_grant;
   vec_t o_input_grant;
   logic o_err;

   exp_t sb[$];
   int   checks;
   int   errors;

   lib_switch_allocator #(.RADIX(5)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .i_req          (i_req),
      .i_en           (i_en),
      .o_output_grant (o_output_grant),
      .o_input_grant  (o_input_grant),
      .o_err          (o_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t oh(input int i);
      vec_t r;
      r = '0;
      r[i] = 1'b1;
      return r;
   endfunction

   // Drive at posedge+1, compare at posedge+2, then advance one edge.
   task automatic step(input string tag, input mat_t req, input vec_t en,
                       input mat_t eog, input vec_t eig, input logic eerr);
      exp_t e;
      exp_t g;
      i_req = req;
      i_en  = en;
      e.tag = tag; e.og = eog; e.ig = eig; e.err = eerr;
      sb.push_back(e);
      #1;
      g = sb.pop_front();
      checks++;
      assert (o_output_grant === g.og) else begin
         errors++;
         $error("FAIL %s og got %h exp %h", g.tag, o_output_grant, g.og);
      end
      checks++;
      assert (o_input_grant === g.ig) else begin
         errors++;
         $error("FAIL %s ig got %b exp %b", g.tag, o_input_grant, g.ig);
      end
      checks++;
      assert (o_err === g.err) else begin
         errors++;
         $error("FAIL %s err got %b exp %b", g.tag, o_err, g.err);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
   endtask

   initial begin
      mat_t r;
      mat_t e;
      vec_t all;
      checks  = 0;
      errors  = 0;
      all     = 5'b11111;
      reset_n = 1'b0;
      i_req   = '0;
      i_en    = '0;
      @(posedge clk);
      #1;

      // Reset holds grants low.
      r = '0; r[1] = 5'b00100;
      step("rst_hold", r, all, '0, '0, 1'b0);
      reset_n = 1'b1;
      e = '0; e[2] = 5'b01000;
      step("rst_rel", r, all, e, 5'b01000, 1'b0);

      // Round-robin on output 2 from a fresh pointer.
      pulse_reset();
      r = '0;
      for (int i = 0; i < 5; i++) r[i] = oh(2);
      for (int n = 0; n < 6; n++) begin
         e = '0; e[2] = oh(n % 5);
         step($sformatf("rr%0d", n), r, all, e, oh(n % 5), 1'b0);
      end

      // Backpressure on output 4.
      r = '0; r[1] = oh(4); r[3] = oh(4);
      for (int n = 0; n < 3; n++)
         step($sformatf("bp_blk%0d", n), r, 5'b11110, '0, '0, 1'b0);
      e = '0; e[4] = oh(1);
      step("bp_go1", r, all, e, oh(1), 1'b0);
      e = '0; e[4] = oh(3);
      step("bp_go3", r, all, e, oh(3), 1'b0);

      // Five independent grants in one cycle.
      r = '0;
      r[0] = oh(0); r[1] = oh(2); r[2] = oh(1); r[3] = oh(4); r[4] = oh(3);
      e = '0;
      e[0] = oh(0); e[2] = oh(1); e[1] = oh(2); e[4] = oh(3); e[3] = oh(4);
      step("par", r, all, e, 5'b11111, 1'b0);

      // Multi-hot requester is ignored and latches the error.
      r = '0; r[2] = 5'b10010; r[0] = oh(3);
      e = '0; e[3] = oh(0);
      step("mh", r, all, e, oh(0), 1'b0);
      step("mh_err", '0, all, '0, '0, 1'b1);
      r = '0; r[4] = oh(0);
      e = '0; e[0] = oh(4);
      step("mh_sticky", r, all, e, oh(4), 1'b1);

      // Mid-stream reset returns pointer of output 1 to input 0.
      r = '0; r[3] = oh(1);
      e = '0; e[1] = oh(3);
      step("mid_pre", r, all, e, oh(3), 1'b1);
      reset_n = 1'b0;
      r = '0; r[0] = oh(1); r[4] = oh(1);
      step("mid_inrst", r, all, '0, '0, 1'b0);
      reset_n = 1'b1;
      e = '0; e[1] = oh(0);
      step("mid_post", r, all, e, oh(0), 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
